// File: rtl/reaction_timer_bcd.sv
// reaction_timer_bcd: measures how long `enable` stays high, in milliseconds,
// as 4-digit packed BCD. It latches each finished run, tracks the best
// (lowest) run that did not overflow, and drives the seven-segment decoders.
// Ports:
//   clock       system clock; all logic on the rising edge
//   reset       synchronous, active-high
//   enable      count enable from the game FSM (high = timing in progress)
//   count_bcd   live count {thousands, hundreds, tens, ones}
//   result_bcd  last completed reaction time
//   best_bcd    best valid time since reset (0x9999 until one is recorded)
//   best_valid  high once a non-overflow result has been recorded
//   done        one-cycle pulse when result_bcd updates
//   overflow    count saturated at 9999 during the current/last run
module reaction_timer_bcd #(
    parameter int TICK_DIV = 50000,
    parameter int PRE_W    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] count_bcd,
    output logic [15:0] result_bcd,
    output logic [15:0] best_bcd,
    output logic        best_valid,
    output logic        done,
    output logic        overflow
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // The state register doubles as the delayed copy of enable used for
    // edge detection.
    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] prescaler;

    logic rise;
    logic fall;
    logic run;
    logic tick;

    // BCD +1: each digit at 9 wraps to 0 and passes the carry upward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = enable ? COUNTING : IDLE;
    end

    // Output/control decode
    always_comb begin
        rise = 1'b0;
        fall = 1'b0;
        run  = 1'b0;
        case (state)
            IDLE:     rise = enable;
            COUNTING: begin
                run  = enable;
                fall = ~enable;
            end
            default:  ;
        endcase
        tick = run && (prescaler == PRE_LAST);
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler  <= '0;
            count_bcd  <= 16'h0000;
            result_bcd <= 16'h0000;
            best_bcd   <= 16'h9999;
            best_valid <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rise) begin
                count_bcd <= 16'h0000;
                prescaler <= '0;
                overflow  <= 1'b0;
            end else if (run) begin
                if (tick) begin
                    prescaler <= '0;
                    // Saturate at 9999 rather than wrap to 0000.
                    if (count_bcd == 16'h9999) begin
                        overflow <= 1'b1;
                    end else begin
                        count_bcd <= bcd_inc(count_bcd);
                    end
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end else if (fall) begin
                result_bcd <= count_bcd;
                done       <= 1'b1;
                prescaler  <= '0;
                // Packed BCD orders like binary, so a plain compare works.
                if (!overflow && (!best_valid || (count_bcd < best_bcd))) begin
                    best_bcd   <= count_bcd;
                    best_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Testbench for reaction_timer_bcd: table-driven runs, hand-written reset
// sequences and random runs, all checked against an arithmetic model.
module tb_reaction_timer_bcd;

    localparam int TD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] count_bcd;
    logic [15:0] result_bcd;
    logic [15:0] best_bcd;
    logic        best_valid;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    reaction_timer_bcd #(.TICK_DIV(TD), .PRE_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .count_bcd  (count_bcd),
        .result_bcd (result_bcd),
        .best_bcd   (best_bcd),
        .best_valid (best_valid),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Model: the run is described by how many consecutive high samples (k)
    // it has had; the displayed count follows from k by arithmetic.
    int          m_k;
    bit          m_prev;
    logic [15:0] m_result;
    int          m_best;
    bit          m_bv;
    bit          m_done;

    function automatic int m_ticks(input int k);
        return (k == 0) ? 0 : (k - 1) / TD;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int m_count();
        return (m_ticks(m_k) > 9999) ? 9999 : m_ticks(m_k);
    endfunction

    function automatic bit m_ovf();
        return m_ticks(m_k) >= 10000;
    endfunction

    task automatic model_update(input logic en, input logic rst);
        if (rst) begin
            m_k = 0; m_prev = 0; m_result = 16'h0000;
            m_best = 9999; m_bv = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (en) begin
                m_k = m_prev ? m_k + 1 : 1;
            end else if (m_prev) begin
                m_result = to_bcd(m_count());
                m_done   = 1;
                if (!m_ovf() && (!m_bv || m_count() < m_best)) begin
                    m_best = m_count();
                    m_bv   = 1;
                end
            end
            m_prev = en;
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive one edge, then compare every output with the model.
    task automatic step(input logic en, input logic rst);
        logic [52:0] act;
        logic [52:0] exp;
        bit          bad_digit;
        enable = en;
        reset  = rst;
        @(posedge clock);
        #1;
        model_update(en, rst);
        act = {count_bcd, result_bcd, best_bcd, best_valid, done, overflow, 2'b00};
        exp = {to_bcd(m_count()), m_result, to_bcd(m_best), m_bv, m_done, m_ovf(), 2'b00};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle: got cnt=%h res=%h best=%h bv=%b done=%b ovf=%b, expected cnt=%h res=%h best=%h bv=%b done=%b ovf=%b",
                     count_bcd, result_bcd, best_bcd, best_valid, done, overflow,
                     exp[52:37], exp[36:21], exp[20:5], exp[4], exp[3], exp[2]);
        end
        bad_digit = 0;
        for (int i = 0; i < 4; i++) if (count_bcd[4*i +: 4] > 4'd9) bad_digit = 1;
        checks++;
        if (bad_digit) begin
            errors++;
            $display("FAIL digit_range: got %h, expected digits 0-9", count_bcd);
        end
    endtask

    typedef struct {
        int          hi;
        logic [15:0] res;
        logic [15:0] best;
        logic        bv;
        logic        ovf;
    } run_t;

    run_t runs[8];

    initial begin
        runs[0] = '{49,    16'h0012, 16'h0012, 1'b1, 1'b0};
        runs[1] = '{401,   16'h0100, 16'h0012, 1'b1, 1'b0};
        runs[2] = '{4001,  16'h1000, 16'h0012, 1'b1, 1'b0};
        runs[3] = '{40021, 16'h9999, 16'h0012, 1'b1, 1'b1};
        runs[4] = '{49,    16'h0012, 16'h0012, 1'b1, 1'b0};
        runs[5] = '{81,    16'h0020, 16'h0012, 1'b1, 1'b0};
        runs[6] = '{29,    16'h0007, 16'h0007, 1'b1, 1'b0};
        runs[7] = '{1,     16'h0000, 16'h0000, 1'b1, 1'b0};

        // Reset values
        step(0, 1);
        step(0, 1);
        check16("rst_count", count_bcd, 16'h0000);
        check16("rst_result", result_bcd, 16'h0000);
        check16("rst_best", best_bcd, 16'h9999);
        check1("rst_bv", best_valid, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_ovf", overflow, 1'b0);
        step(0, 0);

        // Table-driven runs
        foreach (runs[r]) begin
            for (int i = 0; i < runs[r].hi; i++) step(1, 0);
            step(0, 0);
            check1($sformatf("run%0d_done_hi", r), done, 1'b1);
            check16($sformatf("run%0d_result", r), result_bcd, runs[r].res);
            step(0, 0);
            check1($sformatf("run%0d_done_lo", r), done, 1'b0);
            check16($sformatf("run%0d_count_hold", r), count_bcd, runs[r].res);
            check16($sformatf("run%0d_best", r), best_bcd, runs[r].best);
            check1($sformatf("run%0d_bv", r), best_valid, runs[r].bv);
            check1($sformatf("run%0d_ovf", r), overflow, runs[r].ovf);
        end

        // Overflow clears on the next rise
        step(0, 0);
        for (int i = 0; i < 40021; i++) step(1, 0);
        check1("ovf_set", overflow, 1'b1);
        step(0, 0);
        step(1, 0);
        check1("ovf_clear_on_rise", overflow, 1'b0);
        check16("count_clear_on_rise", count_bcd, 16'h0000);
        step(0, 0);
        step(0, 0);

        // Reset mid-count with enable held high
        for (int i = 0; i < 21; i++) step(1, 0);
        check16("mid_count", count_bcd, 16'h0005);
        step(1, 1);
        check16("mid_rst_count", count_bcd, 16'h0000);
        check16("mid_rst_result", result_bcd, 16'h0000);
        check16("mid_rst_best", best_bcd, 16'h9999);
        check1("mid_rst_bv", best_valid, 1'b0);
        check1("mid_rst_done", done, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1, 0);
            check1("mid_no_done", done, 1'b0);
        end
        check16("mid_restart_count", count_bcd, 16'h0002);
        step(0, 0);
        check16("mid_restart_result", result_bcd, 16'h0002);
        check1("mid_restart_done", done, 1'b1);
        step(0, 0);

        // Random runs, with the occasional reset landing inside a run
        for (int r = 0; r < 250; r++) begin
            int hi;
            int lo;
            int rst_at;
            hi     = $urandom_range(1, 45);
            lo     = $urandom_range(1, 4);
            rst_at = ($urandom_range(0, 14) == 0) ? $urandom_range(0, hi - 1) : -1;
            for (int i = 0; i < hi; i++) step(1, i == rst_at);
            for (int i = 0; i < lo; i++) step(0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
